// File: rtl/jtcop_irqctl_if.sv
// Bus bundle between the Data East address decoder / interrupt sources and the
// 68000 interrupt controller. The controller takes the slave side.
interface jtcop_irqctl_if #(
    parameter int CH = 3
);
    logic [CH-1:0] irq_src;
    logic [CH-1:0] clr;
    logic          mask_we;
    logic [CH-1:0] mask_din;
    logic          ASn;
    logic [2:0]    FC;
    logic [2:0]    A;
    logic [2:0]    IPLn;
    logic          VPAn;
    logic [CH-1:0] pending;
    logic [CH-1:0] mask;

    modport master (
        output irq_src, clr, mask_we, mask_din, ASn, FC, A,
        input  IPLn, VPAn, pending, mask
    );

    modport slave (
        input  irq_src, clr, mask_we, mask_din, ASn, FC, A,
        output IPLn, VPAn, pending, mask
    );
endinterface

// File: rtl/jtcop_irqctl.sv
// Parametrised 68000 interrupt controller: CH sources, each with its own IPL level,
// edge/level mode, polarity, mask bit and autovector-acknowledge clear.
module jtcop_irqctl #(
    parameter int            CH      = 3,
    parameter                LEVELS  = {3'd4, 3'd5, 3'd6},
    parameter logic [CH-1:0] EDGE    = 3'b111,
    parameter logic [CH-1:0] POL     = 3'b000,
    parameter logic [CH-1:0] ACKCLR  = 3'b111,
    parameter logic [CH-1:0] MASKRST = 3'b111,
    parameter bit            SYNC    = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    jtcop_irqctl_if.slave  bus
);

    if (CH < 1 || CH > 8 || $bits(LEVELS) != 3 * CH) begin : g_cfg_error
        $error("jtcop_irqctl: CH must be 1..8 and LEVELS must be exactly 3*CH bits");
    end

    localparam logic [3*CH-1:0] LVL   = LEVELS;
    // The edge enable is delayed by the synchroniser depth so the flush of the
    // reset value through the synchroniser never looks like an edge.
    localparam int              ARM_W = SYNC ? 3 : 1;

    logic [CH-1:0]    s;
    logic [CH-1:0]    s_prev;
    logic [ARM_W-1:0] arm_sr;
    logic             arm;
    logic             iack;
    logic             iack_l;
    logic             iack_start;
    logic [CH-1:0]    set_s;
    logic [CH-1:0]    clear_s;
    logic [CH-1:0]    pending_r;
    logic [CH-1:0]    pending_nxt;
    logic [CH-1:0]    mask_r;
    logic [CH-1:0]    en;
    logic [2:0]       lvl_max;
    logic [2:0]       ipl_r;

    if (SYNC) begin : g_sync
        logic [CH-1:0] sync_a;
        logic [CH-1:0] sync_b;

        // Two-flop synchroniser, parked at the inactive level during reset
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_a <= ~POL;
                sync_b <= ~POL;
            end else begin
                sync_a <= bus.irq_src;
                sync_b <= sync_a;
            end
        end

        assign s = ~(sync_b ^ POL);
    end else begin : g_nosync
        assign s = ~(bus.irq_src ^ POL);
    end

    // Previous active sample and edge-enable pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_prev <= {CH{1'b0}};
            arm_sr <= {ARM_W{1'b0}};
        end else begin
            s_prev <= s;
            arm_sr <= ARM_W'({arm_sr, 1'b1});
        end
    end

    assign arm        = arm_sr[ARM_W-1];
    assign set_s      = {CH{arm}} & s & ~s_prev;

    assign iack       = ~bus.ASn & (bus.FC == 3'b111);
    assign iack_start = iack & ~iack_l;
    assign bus.VPAn   = ~iack;

    // IACK cycle tracker so a long ASn low produces a single clear pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iack_l <= 1'b0;
        end else begin
            iack_l <= iack;
        end
    end

    // Per-channel clear: decoder strobe or autovector acknowledge at this level
    always_comb begin
        clear_s = {CH{1'b0}};
        for (int i = 0; i < CH; i++) begin
            if (iack_start && ACKCLR[i] && (LVL[3*i +: 3] == bus.A)) begin
                clear_s[i] = 1'b1;
            end else begin
                clear_s[i] = bus.clr[i];
            end
        end
    end

    // Next pending state; a new edge beats a simultaneous clear
    always_comb begin
        pending_nxt = pending_r;
        for (int i = 0; i < CH; i++) begin
            if (!EDGE[i]) begin
                pending_nxt[i] = s[i];
            end else if (set_s[i]) begin
                pending_nxt[i] = 1'b1;
            end else if (clear_s[i]) begin
                pending_nxt[i] = 1'b0;
            end else begin
                pending_nxt[i] = pending_r[i];
            end
        end
    end

    // Pending and mask registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_r <= {CH{1'b0}};
            mask_r    <= MASKRST;
        end else begin
            pending_r <= pending_nxt;
            if (bus.mask_we) begin
                mask_r <= bus.mask_din;
            end else begin
                mask_r <= mask_r;
            end
        end
    end

    assign en = pending_r & mask_r;

    // Highest level among enabled channels; level 0 can never win
    always_comb begin
        lvl_max = 3'd0;
        for (int i = 0; i < CH; i++) begin
            if (en[i] && (LVL[3*i +: 3] > lvl_max)) begin
                lvl_max = LVL[3*i +: 3];
            end else begin
                lvl_max = lvl_max;
            end
        end
    end

    // Registered active-low priority to the CPU
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ipl_r <= 3'b111;
        end else begin
            ipl_r <= ~lvl_max;
        end
    end

    assign bus.IPLn    = ipl_r;
    assign bus.pending = pending_r;
    assign bus.mask    = mask_r;

endmodule

// File: tb/tb_jtcop_irqctl.sv
// Self-checking bench for jtcop_irqctl: a cycle model of the interrupt rules checked
// every negedge, plus directed scenarios with hand-computed literal expectations.
module tb_jtcop_irqctl;
    localparam int         CH      = 3;
    localparam logic [8:0] LEVELS  = {3'd4, 3'd5, 3'd6};
    localparam logic [2:0] EDGE    = 3'b111;
    localparam logic [2:0] POL     = 3'b000;
    localparam logic [2:0] ACKCLR  = 3'b111;
    localparam logic [2:0] MASKRST = 3'b111;
    localparam bit         SYNC    = 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    jtcop_irqctl_if #(.CH(CH)) bus ();

    jtcop_irqctl #(
        .CH(CH), .LEVELS(LEVELS), .EDGE(EDGE), .POL(POL),
        .ACKCLR(ACKCLR), .MASKRST(MASKRST), .SYNC(SYNC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // act_hist[k] = active-level samples of irq_src taken k edges ago (k=0 this edge)
    logic [CH-1:0] act_hist [0:3];
    int            m_n;
    logic [CH-1:0] m_pend;
    logic [CH-1:0] m_mask;
    logic [2:0]    m_ipl;
    logic          m_iack_prev;
    logic          m_iack_now;
    logic          m_set;
    logic          m_clear;

    function automatic logic [2:0] lvl(input int i);
        return LEVELS[3*i +: 3];
    endfunction

    function automatic logic [2:0] top_level(input logic [CH-1:0] en);
        int best = 0;
        for (int i = 0; i < CH; i++)
            if (en[i] && int'(lvl(i)) > best) best = int'(lvl(i));
        return 3'(best);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) act_hist[k] = '0;
            m_n         = 0;
            m_pend      = '0;
            m_mask      = MASKRST;
            m_ipl       = 3'b111;
            m_iack_prev = 1'b0;
        end else begin
            m_n = m_n + 1;
            for (int k = 3; k > 0; k--) act_hist[k] = act_hist[k-1];
            act_hist[0] = ~(bus.irq_src ^ POL);
            m_iack_now = !bus.ASn && (bus.FC == 3'd7);
            m_ipl = ~top_level(m_pend & m_mask);
            for (int i = 0; i < CH; i++) begin
                // a sample becomes visible two edges later; edges before the
                // second post-reset sample are ignored
                m_set   = (m_n >= 4) && act_hist[2][i] && !act_hist[3][i];
                m_clear = bus.clr[i] ||
                          (m_iack_now && !m_iack_prev && ACKCLR[i] && lvl(i) == bus.A);
                if (!EDGE[i])     m_pend[i] = act_hist[2][i];
                else if (m_set)   m_pend[i] = 1'b1;
                else if (m_clear) m_pend[i] = 1'b0;
            end
            if (bus.mask_we) m_mask = bus.mask_din;
            m_iack_prev = m_iack_now;
        end
    end

    always @(negedge clk) begin
        chk("ipln_model",    8'(bus.IPLn),    8'(m_ipl));
        chk("pending_model", 8'(bus.pending), 8'(m_pend));
        chk("mask_model",    8'(bus.mask),    8'(m_mask));
        chk("vpan_model",    8'(bus.VPAn),    8'(!(!bus.ASn && bus.FC == 3'd7)));
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.irq_src  = 3'b011;
        bus.clr      = 3'b000;
        bus.mask_we  = 1'b0;
        bus.mask_din = 3'b000;
        bus.ASn      = 1'b1;
        bus.FC       = 3'd0;
        bus.A        = 3'd0;
        step(3);
        chk("reset_ipln",    8'(bus.IPLn),    8'h07);
        chk("reset_pending", 8'(bus.pending), 8'h00);
        chk("reset_mask",    8'(bus.mask),    8'h07);
        chk("reset_vpan",    8'(bus.VPAn),    8'h01);

        // ch2 held active through reset release: nothing pends until it toggles
        rst = 1'b0;
        step(8);
        chk("t6_no_pend", 8'(bus.pending), 8'h00);
        bus.irq_src = 3'b111;
        step(4);
        bus.irq_src = 3'b011;
        step(2);
        chk("t6_not_yet", 8'(bus.pending), 8'h00);
        step(1);
        chk("t6_pend2",   8'(bus.pending), 8'h04);
        step(1);
        chk("t6_ipl4",    8'(bus.IPLn),    8'h03);
        bus.clr = 3'b100;
        step(1);
        bus.clr = 3'b000;
        chk("t6_cleared", 8'(bus.pending), 8'h00);
        bus.irq_src = 3'b111;
        step(4);

        // falling edge on ch0: pending at +3, IPLn at +4
        bus.irq_src = 3'b110;
        step(2);
        chk("t1_plus2",   8'(bus.pending), 8'h00);
        step(1);
        chk("t1_plus3",   8'(bus.pending), 8'h01);
        chk("t1_ipl_lag", 8'(bus.IPLn),    8'h07);
        step(1);
        chk("t1_plus4",   8'(bus.IPLn),    8'h01);
        bus.clr = 3'b001;
        step(1);
        bus.clr = 3'b000;

        // ch1 (L5) and ch2 (L4) pending, then clear ch1
        bus.irq_src = 3'b001;
        step(4);
        chk("t2_ipl5",  8'(bus.IPLn),    8'h02);
        chk("t2_pend",  8'(bus.pending), 8'h06);
        bus.clr = 3'b010;
        step(1);
        bus.clr = 3'b000;
        chk("t2_clr1",  8'(bus.pending), 8'h04);
        chk("t2_lag",   8'(bus.IPLn),    8'h02);
        step(1);
        chk("t2_ipl4",  8'(bus.IPLn),    8'h03);

        // long IACK at level 6: one clear only, even with a new ch0 edge inside it
        bus.irq_src = 3'b000;
        step(4);
        chk("t3_ipl6",  8'(bus.IPLn),    8'h01);
        bus.ASn = 1'b0;
        bus.FC  = 3'd7;
        bus.A   = 3'd6;
        #1;
        chk("t3_vpan",  8'(bus.VPAn),    8'h00);
        step(1);
        chk("t3_clr0",  8'(bus.pending), 8'h04);
        bus.irq_src = 3'b001;
        step(1);
        bus.irq_src = 3'b000;
        step(3);
        chk("t3_once",  8'(bus.pending), 8'h05);
        bus.ASn = 1'b1;
        bus.FC  = 3'd0;
        bus.A   = 3'd0;
        step(1);

        // IACK at a level with nothing pending, and a non-IACK function code
        bus.ASn = 1'b0;
        bus.FC  = 3'd7;
        bus.A   = 3'd3;
        #1;
        chk("iack3_vpan", 8'(bus.VPAn),    8'h00);
        step(2);
        chk("iack3_keep", 8'(bus.pending), 8'h05);
        bus.FC = 3'd6;
        #1;
        chk("fc6_vpan",   8'(bus.VPAn),    8'h01);
        bus.ASn = 1'b1;
        bus.FC  = 3'd0;
        step(1);

        // new ch0 edge in the same cycle as clr[0]: set wins
        bus.clr = 3'b111;
        step(1);
        bus.clr = 3'b000;
        chk("t4_clear_all", 8'(bus.pending), 8'h00);
        bus.irq_src = 3'b001;
        step(3);
        bus.irq_src = 3'b000;
        step(2);
        bus.clr = 3'b001;
        step(1);
        bus.clr = 3'b000;
        chk("t4_set_wins",  8'(bus.pending), 8'h01);

        // masking hides ch0 without clearing it
        step(1);
        chk("t5_ipl6",    8'(bus.IPLn),    8'h01);
        bus.mask_we  = 1'b1;
        bus.mask_din = 3'b110;
        step(1);
        bus.mask_we  = 1'b0;
        chk("t5_mask",    8'(bus.mask),    8'h06);
        step(1);
        chk("t5_ipl7",    8'(bus.IPLn),    8'h07);
        chk("t5_keep",    8'(bus.pending), 8'h01);
        bus.mask_we  = 1'b1;
        bus.mask_din = 3'b111;
        step(1);
        bus.mask_we  = 1'b0;
        step(1);
        chk("t5_restore", 8'(bus.IPLn),    8'h01);

        // asynchronous reset while a channel is pending
        rst = 1'b1;
        #1;
        chk("t6_rst_pending", 8'(bus.pending), 8'h00);
        chk("t6_rst_ipln",    8'(bus.IPLn),    8'h07);
        chk("t6_rst_mask",    8'(bus.mask),    8'h07);
        step(2);
        rst = 1'b0;
        step(6);
        chk("t6_rst_quiet",   8'(bus.pending), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
